pack_receive: RTL and testbench

Byte-stream receiver and packet reassembler, the opposite end of the packet-to-byte sender link. It watches an incoming byte stream for the `FF FF FF 7F` sync sequence and locks framing to it. Once locked, it rebuilds 16-byte frames into 128-bit packet words, byte 0 in bits [7:0]. Packets go to the downstream consumer over a level-available/pulse-acknowledge handshake, with overflow reporting.

---
 rtl/pack_receive.sv | 124 ++++++++++++
 tb/tb_pack_receive.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pack_receive.sv
// Byte-stream receiver: locks framing on the FF FF FF 7F sync sequence and
// reassembles 16-byte frames into 128-bit packets for a downstream consumer.
module pack_receive #(
    parameter int SYNC_TIMEOUT     = 64,
    parameter int OVF_STRETCH_BITS = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   DataIn,
    input  logic         DataValid,
    output logic [127:0] PacketOut,
    output logic         PacketAvail,
    input  logic         PacketAvailAck,
    output logic         sync,
    output logic         DataOverf
);

    localparam int TW = (SYNC_TIMEOUT > 0) ? $clog2(SYNC_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(SYNC_TIMEOUT - 1);
    localparam logic [OVF_STRETCH_BITS-1:0] STRETCH_FULL = {OVF_STRETCH_BITS{1'b1}};

    typedef enum logic [0:0] {
        UNSYNCED = 1'b0,
        SYNCED   = 1'b1
    } state_t;

    state_t                      state_r;
    logic [1:0]                  ffCnt_r;
    logic [3:0]                  byteIdx_r;
    logic [127:0]                assembly_r;
    logic [TW-1:0]               toCnt_r;
    logic [OVF_STRETCH_BITS-1:0] stretch_r;

    logic         syncHit_s;
    logic         storeByte_s;
    logic         complete_s;
    logic         timeoutHit_s;
    logic [127:0] newPacket_s;

    // Decode this cycle's byte: sync hit, slot write, packet completion, timeout.
    always_comb begin
        syncHit_s    = 1'b0;
        storeByte_s  = 1'b0;
        complete_s   = 1'b0;
        timeoutHit_s = 1'b0;
        newPacket_s  = {DataIn, assembly_r[119:0]};
        if (DataValid) begin
            syncHit_s   = (DataIn == 8'h7F) && (ffCnt_r == 2'd3);
            storeByte_s = (state_r == SYNCED) && !syncHit_s;
        end else begin
            syncHit_s   = 1'b0;
            storeByte_s = 1'b0;
        end
        complete_s = storeByte_s && (byteIdx_r == 4'd15);
        if (SYNC_TIMEOUT != 0) begin
            timeoutHit_s = complete_s && (toCnt_r == TO_LAST);
        end else begin
            timeoutHit_s = 1'b0;
        end
    end

    // Framing FSM, assembly buffer, holding register and overflow stretch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= UNSYNCED;
            ffCnt_r     <= 2'd0;
            byteIdx_r   <= 4'd0;
            assembly_r  <= 128'd0;
            toCnt_r     <= {TW{1'b0}};
            stretch_r   <= {OVF_STRETCH_BITS{1'b0}};
            PacketOut   <= 128'd0;
            PacketAvail <= 1'b0;
            sync        <= 1'b0;
            DataOverf   <= 1'b0;
        end else begin
            DataOverf <= (stretch_r != {OVF_STRETCH_BITS{1'b0}});
            if (stretch_r != {OVF_STRETCH_BITS{1'b0}}) begin
                stretch_r <= stretch_r - OVF_STRETCH_BITS'(1);
            end

            // The FF counter runs in every state so a sync can be found anywhere.
            if (DataValid) begin
                if (DataIn == 8'hFF) begin
                    ffCnt_r <= (ffCnt_r == 2'd3) ? 2'd3 : ffCnt_r + 2'd1;
                end else begin
                    ffCnt_r <= 2'd0;
                end
            end

            if (PacketAvailAck && PacketAvail) begin
                PacketAvail <= 1'b0;
            end

            if (syncHit_s) begin
                state_r    <= SYNCED;
                sync       <= 1'b1;
                byteIdx_r  <= 4'd0;
                toCnt_r    <= {TW{1'b0}};
                assembly_r <= 128'd0;
            end else if (storeByte_s) begin
                assembly_r[{byteIdx_r, 3'b000} +: 8] <= DataIn;
                byteIdx_r <= byteIdx_r + 4'd1;
                if (complete_s) begin
                    // An ack on the completing edge frees the holding register.
                    if (!PacketAvail || PacketAvailAck) begin
                        PacketOut   <= newPacket_s;
                        PacketAvail <= 1'b1;
                    end else begin
                        stretch_r <= STRETCH_FULL;
                    end
                    if (timeoutHit_s) begin
                        state_r   <= UNSYNCED;
                        sync      <= 1'b0;
                        byteIdx_r <= 4'd0;
                        toCnt_r   <= {TW{1'b0}};
                    end else if (SYNC_TIMEOUT != 0) begin
                        toCnt_r <= toCnt_r + TW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pack_receive.sv
// Scoreboard bench for pack_receive: default instance plus a SYNC_TIMEOUT=2 instance.
module tb_pack_receive;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   DataIn;
    logic         DataValid;
    logic         PacketAvailAck;
    logic [127:0] out64, out2;
    logic         avail64, avail2, sync64, sync2, ovf64, ovf2;

    int nTests = 0;
    int nFail  = 0;

    logic [127:0] q64[$];
    logic [127:0] q2[$];
    logic         mon64En = 1'b1;
    logic         mon2En  = 1'b0;
    logic         prevAvail64 = 1'b0, prevAvail2 = 1'b0;
    logic [127:0] prevOut64 = 128'd0, prevOut2 = 128'd0;

    always #5 clk = ~clk;

    pack_receive dut (
        .clk(clk), .rst(rst), .DataIn(DataIn), .DataValid(DataValid),
        .PacketOut(out64), .PacketAvail(avail64), .PacketAvailAck(PacketAvailAck),
        .sync(sync64), .DataOverf(ovf64)
    );

    pack_receive #(.SYNC_TIMEOUT(2)) dutTo (
        .clk(clk), .rst(rst), .DataIn(DataIn), .DataValid(DataValid),
        .PacketOut(out2), .PacketAvail(avail2), .PacketAvailAck(PacketAvailAck),
        .sync(sync2), .DataOverf(ovf2)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mkPkt(input logic [7:0] base);
        logic [127:0] p;
        for (int k = 0; k < 16; k++) p[8*k +: 8] = 8'(base + k);
        return p;
    endfunction

    // Delivery monitors: a new packet appears when PacketAvail rises or PacketOut changes.
    always @(negedge clk) begin
        logic [127:0] e;
        if (mon64En && avail64 && (!prevAvail64 || out64 != prevOut64)) begin
            e = (q64.size() != 0) ? q64.pop_front() : {128{1'b1}};
            chk("pkt64", out64, e);
        end
        if (mon2En && avail2 && (!prevAvail2 || out2 != prevOut2)) begin
            e = (q2.size() != 0) ? q2.pop_front() : {128{1'b1}};
            chk("pkt2", out2, e);
        end
        prevAvail64 <= avail64;
        prevOut64   <= out64;
        prevAvail2  <= avail2;
        prevOut2    <= out2;
    end

    task automatic sendByte(input logic [7:0] b);
        DataIn    = b;
        DataValid = 1'b1;
        @(posedge clk);
        #1;
        DataValid = 1'b0;
    endtask

    task automatic sendSync(input int nFF);
        for (int i = 0; i < nFF; i++) sendByte(8'hFF);
        sendByte(8'h7F);
    endtask

    task automatic sendFrame(input logic [7:0] base, input logic ackLast);
        for (int k = 0; k < 16; k++) begin
            if (k == 15 && ackLast) PacketAvailAck = 1'b1;
            sendByte(8'(base + k));
            PacketAvailAck = 1'b0;
        end
    endtask

    task automatic doAck;
        PacketAvailAck = 1'b1;
        @(posedge clk);
        #1;
        PacketAvailAck = 1'b0;
    endtask

    task automatic doReset;
        rst            = 1'b0;
        DataValid      = 1'b0;
        DataIn         = 8'h00;
        PacketAvailAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int ovfCnt;
        doReset();
        chk("rstOut", out64, 128'd0);
        chk("rstAvail", 128'(avail64), 128'd0);
        chk("rstSync", 128'(sync64), 128'd0);
        chk("rstOvf", 128'(ovf64), 128'd0);

        // 1. unsynced bytes are discarded
        for (int i = 0; i < 32; i++) sendByte(8'(i));
        chk("t1Sync", 128'(sync64), 128'd0);
        chk("t1Avail", 128'(avail64), 128'd0);

        // 2. basic lock and packet
        sendSync(3);
        chk("t2Sync", 128'(sync64), 128'd1);
        q64.push_back(mkPkt(8'h00));
        for (int k = 0; k < 15; k++) sendByte(8'(k));
        chk("t2AvailEarly", 128'(avail64), 128'd0);
        sendByte(8'h0F);
        chk("t2Avail", 128'(avail64), 128'd1);
        chk("t2Out", out64, 128'h0F0E0D0C0B0A09080706050403020100);
        doAck();
        chk("t2Ack", 128'(avail64), 128'd0);

        // 3. realignment at index 5 with a 4-FF sync
        for (int k = 0; k < 5; k++) sendByte(8'(8'h10 + k));
        sendSync(4);
        q64.push_back(mkPkt(8'hA0));
        sendFrame(8'hA0, 1'b0);
        chk("t3Out", out64, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        doAck();

        // 4. overflow: second packet dropped, stretched indication, ack on completion
        sendSync(3);
        q64.push_back(mkPkt(8'h30));
        sendFrame(8'h30, 1'b0);
        sendFrame(8'h40, 1'b0);
        chk("t4Retain", out64, mkPkt(8'h30));
        chk("t4Avail", 128'(avail64), 128'd1);
        ovfCnt = 0;
        for (int i = 0; i < 2100; i++) begin
            if (ovf64) ovfCnt++;
            @(posedge clk);
            #1;
        end
        chk("t4OvfLen", 128'(ovfCnt), 128'd2047);
        chk("t4OvfOff", 128'(ovf64), 128'd0);
        q64.push_back(mkPkt(8'h60));
        sendFrame(8'h60, 1'b1);
        chk("t4AckSame", 128'(avail64), 128'd1);
        chk("t4Out3", out64, mkPkt(8'h60));
        chk("t4NoOvf", 128'(ovf64), 128'd0);
        doAck();
        @(negedge clk);
        chk("t4Sb", 128'(q64.size()), 128'd0);

        // 5. timeout after two packets with SYNC_TIMEOUT=2
        mon64En = 1'b0;
        doReset();
        mon2En = 1'b1;
        sendSync(3);
        chk("t5Sync", 128'(sync2), 128'd1);
        q2.push_back(mkPkt(8'h50));
        sendFrame(8'h50, 1'b0);
        chk("t5Sync1", 128'(sync2), 128'd1);
        doAck();
        q2.push_back(mkPkt(8'h70));
        sendFrame(8'h70, 1'b0);
        chk("t5Avail2", 128'(avail2), 128'd1);
        chk("t5Lost", 128'(sync2), 128'd0);
        doAck();
        sendFrame(8'h80, 1'b0);
        chk("t5Ignored", 128'(avail2), 128'd0);
        chk("t5StillLost", 128'(sync2), 128'd0);
        @(negedge clk);
        chk("t5Sb", 128'(q2.size()), 128'd0);
        mon2En = 1'b0;

        // 6. asynchronous reset mid-packet
        doReset();
        @(negedge clk);
        mon64En = 1'b1;
        sendSync(3);
        q64.push_back(mkPkt(8'h90));
        sendFrame(8'h90, 1'b0);
        for (int k = 0; k < 7; k++) sendByte(8'(8'hB0 + k));
        chk("t6PreSync", 128'(sync64), 128'd1);
        chk("t6PreAvail", 128'(avail64), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6RstOut", out64, 128'd0);
        chk("t6RstAvail", 128'(avail64), 128'd0);
        chk("t6RstSync", 128'(sync64), 128'd0);
        chk("t6RstOvf", 128'(ovf64), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sendFrame(8'hC0, 1'b0);
        chk("t6NoPkt", 128'(avail64), 128'd0);
        chk("t6NoSync", 128'(sync64), 128'd0);
        @(negedge clk);
        chk("t6Sb", 128'(q64.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
